// File: rtl/triangular_stream_pkg.sv
// Shared types and helpers for the triangular extraction engine.
// Optional feature macro: TRI_TLAST_EN (end-of-matrix marker on the output stream).
package tri_pkg;

   // Matrix-wide mode. "pack" is the packed-output selector; the word packed is reserved.
   typedef struct packed {
      logic lower;
      logic strict;
      logic pack;
   } tri_mode_t;

   localparam tri_mode_t TRI_MODE_RESET = '0;   // upper, inclusive, full

   typedef enum logic {S_IDLE, S_STREAM} tri_state_t;

   // Returns 1 when element (row, col) belongs to the selected triangle.
   function automatic logic tri_keep(input int row, input int col, input tri_mode_t m);
      if (m.lower) return m.strict ? (col < row) : (col <= row);
      else         return m.strict ? (col > row) : (col >= row);
   endfunction

   // Returns 1 when (row, col) is the last kept element of a matrix in row-major order.
   // Upper triangles end in the last column; lower triangles end in the last row.
   // A negative coordinate means the triangle is empty for this shape.
   function automatic logic tri_last_kept(input int row, input int col, input tri_mode_t m,
                                          input int rows, input int cols);
      int lr;
      int lc;
      if (!m.lower) begin
         lc = cols - 1;
         lr = m.strict ? cols - 2 : cols - 1;
         if (lr > rows - 1) lr = rows - 1;
      end else begin
         lr = rows - 1;
         lc = m.strict ? rows - 2 : rows - 1;
         if (lc > cols - 1) lc = cols - 1;
      end
      return (lr >= 0) && (lc >= 0) && (row == lr) && (col == lc);
   endfunction

endpackage

// File: rtl/triangular_stream_if.sv
// Input and output element streams of the triangular extraction engine.
interface triangular_stream_if #(parameter int DATA_WIDTH = 32) ();
   logic [DATA_WIDTH-1:0] in_tdata;
   logic                  in_tvalid;
   logic                  in_tready;
   logic [DATA_WIDTH-1:0] out_tdata;
   logic                  out_tvalid;
   logic                  out_tready;

   // Engine side
   modport slave  (input  in_tdata, in_tvalid, out_tready,
                   output in_tready, out_tdata, out_tvalid);
   // Producer/consumer side
   modport master (output in_tdata, in_tvalid, out_tready,
                   input  in_tready, out_tdata, out_tvalid);
endinterface

// File: rtl/triangular_stream_index_counter.sv
// Row-major (row, col) position of the next input element within a matrix.
module tri_index_counter
   import tri_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   localparam int RW = $clog2((ROWS < 2) ? 2 : ROWS),
   localparam int CW = $clog2((COLS < 2) ? 2 : COLS)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_adv,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_col,
   output logic          o_first,
   output logic          o_last
);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;

   // Step one element per handshake; column wraps into the next row, last element wraps to (0,0).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_adv) begin
         if (r_col == COL_MAX) begin
            r_col <= '0;
            r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row   = r_row;
   assign o_col   = r_col;
   assign o_first = (r_row == '0) && (r_col == '0);
   assign o_last  = (r_row == ROW_MAX) && (r_col == COL_MAX);
endmodule

// File: rtl/triangular_stream.sv
// Streaming triangular extraction: row-major matrix in, upper/lower triangle out,
// packed or zero-filled, through a single backpressure-safe output register.
// Optional feature macro: TRI_TLAST_EN adds a registered out_tlast port.
module triangular_stream
   import tri_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 32,
   localparam int RW = $clog2((ROWS < 2) ? 2 : ROWS),
   localparam int CW = $clog2((COLS < 2) ? 2 : COLS)
)(
   input  logic               clk,
   input  logic               rst,
   triangular_stream_if.slave strm,
   input  logic               mode_lower,
   input  logic               mode_strict,
   input  logic               mode_packed,
   output logic               busy
`ifdef TRI_TLAST_EN
   ,
   output logic               out_tlast
`endif
);
   logic [RW-1:0]         w_row;
   logic [CW-1:0]         w_col;
   logic                  w_first, w_last;
   logic                  w_in_hs, w_keep, w_emit;
   tri_mode_t             w_pin_mode, w_mode, r_mode;
   tri_state_t            r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;

   tri_index_counter #(.ROWS(ROWS), .COLS(COLS)) u_idx (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_in_hs),
      .o_row   (w_row),
      .o_col   (w_col),
      .o_first (w_first),
      .o_last  (w_last)
   );

   // Accept whenever the output register is empty or being drained this cycle.
   assign strm.in_tready = !r_out_valid || strm.out_tready;
   assign w_in_hs        = strm.in_tvalid && strm.in_tready;

   // The first element of a matrix uses the pins directly; the rest use the latched copy.
   assign w_pin_mode = '{lower: mode_lower, strict: mode_strict, pack: mode_packed};
   assign w_mode     = w_first ? w_pin_mode : r_mode;
   assign w_keep     = tri_keep(int'(w_row), int'(w_col), w_mode);
   assign w_emit     = w_in_hs && (w_keep || !w_mode.pack);

   // Latch the mode at the start of each matrix.
   always_ff @(posedge clk) begin
      if (rst)                      r_mode <= TRI_MODE_RESET;
      else if (w_in_hs && w_first)  r_mode <= w_pin_mode;
   end

   // Idle/stream state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Enter STREAM on the first element, leave on the last (1x1 matrices never leave IDLE).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_in_hs && !w_last) w_state_nxt = S_STREAM;
         S_STREAM: if (w_in_hs &&  w_last) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   assign busy = (r_state == S_STREAM);

   // Output register: load on emit, otherwise clear valid once the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_keep ? strm.in_tdata : '0;
      end else if (strm.out_tready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign strm.out_tvalid = r_out_valid;
   assign strm.out_tdata  = r_out_data;

`ifdef TRI_TLAST_EN
   logic w_tlast;
   logic r_out_last;

   // Full mode ends on the last element; packed mode ends on the last kept one.
   assign w_tlast = w_mode.pack ? tri_last_kept(int'(w_row), int'(w_col), w_mode, ROWS, COLS)
                                : w_last;

   // End-of-matrix flag travels with the data register.
   always_ff @(posedge clk) begin
      if (rst)         r_out_last <= 1'b0;
      else if (w_emit) r_out_last <= w_tlast;
   end

   assign out_tlast = r_out_last;
`endif
endmodule

// File: tb/tb_triangular_stream.sv
// Bench for triangular_stream: a 4x4 and a 2x3 instance share one stimulus; sel picks
// which one is observed. Expected outputs come from an index-arithmetic queue model.
module tb_triangular_stream;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic [31:0] in_tdata = '0;
   logic        in_tvalid = 1'b0;
   logic        out_tready = 1'b1;
   logic        p_lower = 1'b0, p_strict = 1'b0, p_packed = 1'b0;
   logic        busy_a, busy_b;

   triangular_stream_if #(.DATA_WIDTH(32)) ifa ();
   triangular_stream_if #(.DATA_WIDTH(32)) ifb ();

   assign ifa.in_tdata   = in_tdata;
   assign ifa.in_tvalid  = in_tvalid;
   assign ifa.out_tready = out_tready;
   assign ifb.in_tdata   = in_tdata;
   assign ifb.in_tvalid  = in_tvalid;
   assign ifb.out_tready = out_tready;

`ifdef TRI_TLAST_EN
   logic tl_a, tl_b, o_tlast;
   assign o_tlast = sel ? tl_b : tl_a;
`endif

   triangular_stream #(.ROWS(4), .COLS(4), .DATA_WIDTH(32)) u4 (
      .clk(clk), .rst(rst), .strm(ifa.slave),
      .mode_lower(p_lower), .mode_strict(p_strict), .mode_packed(p_packed),
      .busy(busy_a)
`ifdef TRI_TLAST_EN
      , .out_tlast(tl_a)
`endif
   );

   triangular_stream #(.ROWS(2), .COLS(3), .DATA_WIDTH(32)) u23 (
      .clk(clk), .rst(rst), .strm(ifb.slave),
      .mode_lower(p_lower), .mode_strict(p_strict), .mode_packed(p_packed),
      .busy(busy_b)
`ifdef TRI_TLAST_EN
      , .out_tlast(tl_b)
`endif
   );

   logic        o_in_tready, o_out_tvalid, o_busy;
   logic [31:0] o_out_tdata;
   assign o_in_tready  = sel ? ifb.in_tready  : ifa.in_tready;
   assign o_out_tvalid = sel ? ifb.out_tvalid : ifa.out_tvalid;
   assign o_out_tdata  = sel ? ifb.out_tdata  : ifa.out_tdata;
   assign o_busy       = sel ? busy_b : busy_a;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   int          total = 0;
   int          bad = 0;
   exp_t        exp_q[$];
   int          got[$];
   logic        gotl[$];
   int          k = 0;
   bit          ml = 0, ms = 0, mp = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit mkeep(input int r, input int c);
      int d;
      d = ml ? (r - c) : (c - r);
      return d >= (ms ? 1 : 0);
   endfunction

   // Reference: element index k in the matrix gives (k/C, k%C); emitted items are queued.
   task automatic model_accept(input logic [31:0] d);
      int   nr, nc, n;
      bit   kp, later;
      exp_t e;
      nr = sel ? 2 : 4;
      nc = sel ? 3 : 4;
      n  = nr * nc;
      if (k == 0) begin
         ml = p_lower; ms = p_strict; mp = p_packed;
      end
      kp = mkeep(k / nc, k % nc);
      later = 0;
      for (int j = k + 1; j < n; j++) if (mkeep(j / nc, j % nc)) later = 1;
      if (kp || !mp) begin
         e.data = kp ? d : 32'd0;
         e.last = mp ? !later : (k == n - 1);
         exp_q.push_back(e);
      end
      k = (k + 1) % n;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_tvalid = 1'b0; out_tready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete(); got.delete(); gotl.delete();
      k = 0; ml = 0; ms = 0; mp = 0;
      chk("rst_tvalid", 64'(o_out_tvalid), 64'd0);
      chk("rst_tdata",  64'(o_out_tdata),  64'd0);
      chk("rst_busy",   64'(o_busy),       64'd0);
      chk("rst_tready", 64'(o_in_tready),  64'd1);
`ifdef TRI_TLAST_EN
      chk("rst_tlast",  64'(o_tlast),      64'd0);
`endif
   endtask

   // One clock: drive, check against the model, account handshakes, advance.
   task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, output logic acc);
      logic        mvalid, hold;
      logic [31:0] hd;
      exp_t        e;
      in_tvalid = v; in_tdata = d; out_tready = ordy;
      #1;
      mvalid = (exp_q.size() != 0);
      chk("out_tvalid", 64'(o_out_tvalid), 64'(mvalid));
      hd = mvalid ? exp_q[0].data : 32'd0;
      if (mvalid) begin
         chk("out_tdata", 64'(o_out_tdata), 64'(hd));
`ifdef TRI_TLAST_EN
         chk("out_tlast", 64'(o_tlast), 64'(exp_q[0].last));
`endif
      end
      chk("in_tready", 64'(o_in_tready), 64'(!mvalid || ordy));
      chk("busy",      64'(o_busy),      64'(k != 0));
      acc  = v && (!mvalid || ordy);
      hold = mvalid && !ordy;
      if (mvalid && ordy) begin
         e = exp_q.pop_front();
         got.push_back(int'(o_out_tdata));
`ifdef TRI_TLAST_EN
         gotl.push_back(o_tlast);
`endif
      end
      if (acc) model_accept(d);
      @(posedge clk); #1;
      if (hold) chk("hold_data", 64'(o_out_tdata), 64'(hd));
   endtask

   task automatic feed(input int first, input int n);
      logic acc;
      int   i = 0;
      int   guard = 0;
      while (i < n && guard < 200) begin
         cycle(1'b1, 32'(first + i), 1'b1, acc);
         if (acc) i++;
         guard++;
      end
      chk("feed_done", 64'(i), 64'(n));
   endtask

   task automatic drain();
      logic acc;
      repeat (3) cycle(1'b0, 32'd0, 1'b1, acc);
   endtask

   task automatic check_list(input string tag, input int expv[$]);
      chk({tag, "_count"}, 64'(got.size()), 64'(expv.size()));
      for (int i = 0; i < expv.size() && i < got.size(); i++)
         chk({tag, "_item"}, 64'(got[i]), 64'(expv[i]));
   endtask

   initial begin
      int   e1[$], e2[$], e3[$], e6[$];
      logic acc;
      int   i, t;
      e1 = '{1, 2, 3, 4, 6, 7, 8, 11, 12, 16};
      e2 = '{0, 0, 0, 0, 5, 0, 0, 0, 9, 10, 0, 0, 13, 14, 15, 0};
      e3 = '{1, 2, 3, 5, 6};
      e6 = '{2, 3, 4, 7, 8, 12, 2, 3, 4, 7, 8, 12};

      // 4x4 upper, inclusive, packed
      sel = 1'b0; do_reset();
      p_lower = 0; p_strict = 0; p_packed = 1;
      feed(1, 16); drain();
      check_list("up_incl_packed", e1);

      // 4x4 lower, strict, full
      do_reset();
      p_lower = 1; p_strict = 1; p_packed = 0;
      feed(1, 16); drain();
      check_list("low_strict_full", e2);

      // 2x3 upper, inclusive, packed
      sel = 1'b1; do_reset();
      p_lower = 0; p_strict = 0; p_packed = 1;
      feed(1, 6); drain();
      check_list("nonsquare", e3);

      // Backpressure stall plus mid-matrix mode pin toggle
      sel = 1'b0; do_reset();
      p_lower = 0; p_strict = 0; p_packed = 1;
      i = 0; t = 0;
      while (i < 16 && t < 100) begin
         p_lower = (i >= 3);
         cycle(1'b1, 32'(i + 1), !(t == 6 || t == 7), acc);
         if (acc) i++;
         t++;
      end
      chk("bp_done", 64'(i), 64'd16);
      p_lower = 0;
      drain();
      check_list("backpressure", e1);

      // Reset mid-matrix, then a fresh matrix
      do_reset();
      feed(1, 7);
      do_reset();
      p_lower = 0; p_strict = 0; p_packed = 1;
      feed(1, 16); drain();
      check_list("after_reset", e1);

      // Back-to-back upper/strict/packed matrices
      do_reset();
      p_lower = 0; p_strict = 1; p_packed = 1;
      feed(1, 16); feed(1, 16); drain();
      check_list("b2b_strict", e6);
`ifdef TRI_TLAST_EN
      for (int j = 0; j < gotl.size(); j++)
         chk("tlast_pattern", 64'(gotl[j]), 64'(j == 5 || j == 11));
`endif

      // Randomised traffic, modes and backpressure on both shapes
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; do_reset();
         repeat (600) begin
            p_lower  = 1'($urandom_range(0, 1));
            p_strict = 1'($urandom_range(0, 1));
            p_packed = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, acc);
         end
         drain();
         chk("rand_empty", 64'(exp_q.size()), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
